// File: rtl/mips_pkg.sv
// Shared constants and types for the fetch/decode slice of the MIPS-style core.
package mips_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  // Bubble: load opcode, rs=01111, rt=00000, offset 0.
  localparam logic [DATA_W-1:0] NOP_WORD = 32'h41E0_0000;

  localparam logic [5:0] OP_LOAD  = 6'b010000;
  localparam logic [5:0] OP_STORE = 6'b010001;
  localparam logic [5:0] OP_RTYPE = 6'b001111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush inserts a bubble (pc kept), load captures, else hold.
module ifid_reg
  import mips_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] instr_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] pc_q;
  logic              valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_q <= NOP_WORD;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, start/halt FSM, branch redirect with flush, stall hold.
// Optional FETCH_PERF_EN adds saturating perf_fetched / perf_stalls counters.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] LAST_ADDR = 10'd25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_instr,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic              ifid_valid,
  output logic [1:0]        state_dbg,
  output logic              halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stalls
`endif
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_RUN    = RUN;
  localparam logic [1:0] ST_HALTED = HALTED;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              load, flush;

  // Per-cycle priority in RUN: redirect beats stall beats normal capture.
  // imem_instr belongs to pc_q and is captured on the same edge.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        flush = 1'b1;
        pc_d  = '0;
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (branch_taken) begin
          pc_d  = branch_target;
          flush = 1'b1;
        end else if (!stall) begin
          load = 1'b1;
          if (pc_q == LAST_ADDR) state_d = ST_HALTED;
          else                   pc_d    = pc_q + 1'b1;
        end
      end
      ST_HALTED: begin
        flush = 1'b1;
        if (branch_taken) begin
          pc_d    = branch_target;
          state_d = ST_RUN;
        end
      end
      default: begin
        flush   = 1'b1;
        pc_d    = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  ifid_reg u_ifid (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (load),
    .flush_i (flush),
    .instr_i (imem_instr),
    .pc_i    (pc_q),
    .instr_o (ifid_instr),
    .pc_o    (ifid_pc),
    .valid_o (ifid_valid)
  );

  assign imem_addr = pc_q;
  assign state_dbg = state_q;
  assign halted    = (state_q == ST_HALTED);

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stalls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stalls_q  <= '0;
    end else begin
      if (load) perf_fetched_q <= sat_inc32(perf_fetched_q);
      if (state_q == ST_RUN && stall && !branch_taken)
        perf_stalls_q <= sat_inc32(perf_stalls_q);
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stalls  = perf_stalls_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized traffic checked
// every cycle against a behavioural model; a second instance runs with LAST_ADDR=1023.
module tb_instruction_fetch;

  localparam logic [31:0] NOP  = 32'h41E0_0000;
  localparam int          LAST = 25;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, start = 1'b0, stall = 1'b0, branch_taken = 1'b0;
  logic [9:0]  branch_target = '0;
  logic [9:0]  imem_addr, ifid_pc;
  logic [31:0] imem_instr, ifid_instr;
  logic        ifid_valid, halted;
  logic [1:0]  state_dbg;

  logic        rst2 = 1'b1, start2 = 1'b0, stall2 = 1'b0, branch2 = 1'b0;
  logic [9:0]  target2 = '0;
  logic [9:0]  imem_addr2, ifid_pc2;
  logic [31:0] imem_instr2, ifid_instr2;
  logic        ifid_valid2, halted2;
  logic [1:0]  state_dbg2;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stalls, perf_fetched2, perf_stalls2;
`endif

  logic [31:0] mem [1024];
  assign imem_instr  = mem[imem_addr];
  assign imem_instr2 = mem[imem_addr2];

  instruction_fetch dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
    .state_dbg(state_dbg), .halted(halted)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stalls(perf_stalls)
`endif
  );

  instruction_fetch #(.LAST_ADDR(10'd1023)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .stall(stall2),
    .branch_taken(branch2), .branch_target(target2),
    .imem_addr(imem_addr2), .imem_instr(imem_instr2),
    .ifid_instr(ifid_instr2), .ifid_pc(ifid_pc2), .ifid_valid(ifid_valid2),
    .state_dbg(state_dbg2), .halted(halted2)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched2), .perf_stalls(perf_stalls2)
`endif
  );

  // scoreboard counters
  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model of the first instance
  int          m_mode = M_IDLE;
  int          m_pc = 0;
  logic [31:0] m_instr = NOP;
  int          m_ifpc = 0;
  bit          m_valid = 1'b0;
  longint      m_perf_f = 0, m_perf_s = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = M_IDLE; m_pc = 0; m_instr = NOP; m_ifpc = 0; m_valid = 0;
      m_perf_f = 0; m_perf_s = 0;
    end else if (m_mode == M_IDLE) begin
      m_instr = NOP; m_valid = 0;
      if (start) m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (branch_taken) begin
        m_pc = int'(branch_target); m_instr = NOP; m_valid = 0;
      end else if (stall) begin
        m_perf_s++;
      end else begin
        m_instr = mem[m_pc]; m_ifpc = m_pc; m_valid = 1; m_perf_f++;
        if (m_pc == LAST) m_mode = M_HALT;
        else              m_pc = (m_pc + 1) % 1024;
      end
    end else begin
      m_instr = NOP; m_valid = 0;
      if (branch_taken) begin
        m_pc = int'(branch_target); m_mode = M_RUN;
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_addr", 64'(imem_addr), 64'(m_pc));
      chk("ifid_instr", 64'(ifid_instr), 64'(m_instr));
      chk("ifid_pc", 64'(ifid_pc), 64'(m_ifpc));
      chk("ifid_valid", 64'(ifid_valid), 64'(m_valid));
      chk("halted", 64'(halted), 64'(m_mode == M_HALT));
      chk("state", 64'(state_dbg), 64'(m_mode));
`ifdef FETCH_PERF_EN
      chk("perf_fetched", 64'(perf_fetched), 64'(m_perf_f));
      chk("perf_stalls", 64'(perf_stalls), 64'(m_perf_s));
`endif
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic reset_start();
    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic run_until_addr(input int a, input int budget);
    int n = 0;
    while (int'(imem_addr) != a && n < budget) begin
      tick(); n++;
    end
    chk("reach_addr", 64'(imem_addr), 64'(a));
  endtask

  function automatic logic [9:0] pick_target();
    case ($urandom_range(0, 2))
      0:       return 10'($urandom_range(0, 30));
      1:       return 10'($urandom_range(1015, 1023));
      default: return 10'($urandom_range(0, 1023));
    endcase
  endfunction

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i);

    // reset state
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_instr", 64'(ifid_instr), 64'(NOP));
    chk("rst_pc", 64'(ifid_pc), 64'd0);
    chk("rst_valid", 64'(ifid_valid), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    rst = 1'b0; tick();
    chk("idle_no_start", 64'(state_dbg), 64'(M_IDLE));

    // sequential run to LAST_ADDR
    start = 1'b1; tick(); start = 1'b0;
    chk("start_no_capture", 64'(ifid_valid), 64'd0);
    for (int k = 0; k <= LAST; k++) begin
      tick();
      chk("seq_pc", 64'(ifid_pc), 64'(k));
      chk("seq_instr", 64'(ifid_instr), 64'(k));
      chk("seq_halted", 64'(halted), 64'(k == LAST));
    end
    tick();
    chk("halt_bubble_instr", 64'(ifid_instr), 64'h41E0_0000);
    chk("halt_bubble_valid", 64'(ifid_valid), 64'd0);
    chk("halt_pc", 64'(imem_addr), 64'd25);
    stall = 1'b1; start = 1'b1; tick(); stall = 1'b0; start = 1'b0;
    chk("halt_ignores", 64'(halted), 64'd1);

    // stall for 3 cycles while ifid_pc=5
    reset_start();
    repeat (6) tick();
    chk("pre_stall_pc", 64'(ifid_pc), 64'd5);
    stall = 1'b1;
    repeat (3) begin
      tick();
      chk("stall_pc", 64'(ifid_pc), 64'd5);
      chk("stall_instr", 64'(ifid_instr), 64'd5);
      chk("stall_addr", 64'(imem_addr), 64'd6);
    end
    stall = 1'b0; tick();
    chk("post_stall_pc", 64'(ifid_pc), 64'd6);
    tick();
    chk("post_stall_pc2", 64'(ifid_pc), 64'd7);

    // redirect at pc=4 to 10
    reset_start();
    run_until_addr(4, 20);
    branch_taken = 1'b1; branch_target = 10'd10; tick(); branch_taken = 1'b0;
    chk("br_addr", 64'(imem_addr), 64'd10);
    chk("br_bubble", 64'(ifid_valid), 64'd0);
    tick();
    chk("br_capture_pc", 64'(ifid_pc), 64'd10);
    chk("br_capture_valid", 64'(ifid_valid), 64'd1);

    // redirect wins over stall
    branch_taken = 1'b1; stall = 1'b1; branch_target = 10'd20; tick();
    branch_taken = 1'b0; stall = 1'b0;
    chk("br_stall_addr", 64'(imem_addr), 64'd20);
    chk("br_stall_bubble", 64'(ifid_valid), 64'd0);

    // reset mid-run at pc=12
    branch_taken = 1'b1; branch_target = 10'd8; tick(); branch_taken = 1'b0;
    run_until_addr(12, 20);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_addr", 64'(imem_addr), 64'd0);
    chk("midrst_state", 64'(state_dbg), 64'(M_IDLE));
    chk("midrst_valid", 64'(ifid_valid), 64'd0);
    repeat (3) tick();
    chk("midrst_needs_start", 64'(imem_addr), 64'd0);

    // full-range instance: LAST_ADDR=1023
    rst2 = 1'b0; start2 = 1'b1; tick(); start2 = 1'b0;
    n = 0;
    while (!halted2 && n < 1200) begin
      tick(); n++;
    end
    chk("d2_halted", 64'(halted2), 64'd1);
    chk("d2_cycles", 64'(n), 64'd1024);
    chk("d2_addr", 64'(imem_addr2), 64'd1023);
    chk("d2_ifid_pc", 64'(ifid_pc2), 64'd1023);
    chk("d2_ifid_instr", 64'(ifid_instr2), 64'd1023);
`ifdef FETCH_PERF_EN
    chk("d2_perf_fetched", 64'(perf_fetched2), 64'd1024);
    chk("d2_perf_stalls", 64'(perf_stalls2), 64'd0);
`endif
    tick();
    chk("d2_bubble", 64'(ifid_valid2), 64'd0);
    branch2 = 1'b1; target2 = 10'd0; tick(); branch2 = 1'b0;
    chk("d2_resume_state", 64'(state_dbg2), 64'(M_RUN));
    chk("d2_resume_addr", 64'(imem_addr2), 64'd0);
    chk("d2_resume_halted", 64'(halted2), 64'd0);
    tick();
    chk("d2_resume_pc", 64'(ifid_pc2), 64'd0);
    chk("d2_resume_valid", 64'(ifid_valid2), 64'd1);
    rst2 = 1'b1;

    // randomized traffic against the model
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    reset_start();
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 199) == 0);
      start         = ($urandom_range(0, 7) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 9) == 0);
      branch_target = pick_target();
      tick();
    end
    rst = 1'b0; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
